// File: rtl/digit_split_seq_pkg.sv
// Shared definitions for the sequential decimal digit splitter.
package digit_split_seq_pkg;

    localparam int DATA_W   = 16;
    localparam int DEC_BASE = 10;
    localparam int NDIG     = 4;
    localparam int DIG_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIN,
        DONE
    } state_t;

endpackage

// File: rtl/digit_split_seq_div10_step.sv
// One restoring divide-by-10 step: shifts one dividend bit into the partial remainder.
module div10_step
    import digit_split_seq_pkg::*;
(
    input  logic [DIG_W-1:0] rem_in,
    input  logic             bit_in,
    output logic [DIG_W-1:0] rem_out,
    output logic             q_bit
);

    logic [DIG_W:0] t;

    assign t       = {rem_in, bit_in};
    assign q_bit   = (t >= (DIG_W+1)'(DEC_BASE));
    assign rem_out = q_bit ? DIG_W'(t - (DIG_W+1)'(DEC_BASE)) : t[DIG_W-1:0];

endmodule

// File: rtl/digit_split_seq.sv
// Converts a signed 16-bit result into sign plus four BCD digits using one
// time-shared divide-by-10 step, 16 cycles per digit.
module digit_split_seq
    import digit_split_seq_pkg::*;
#(
    parameter bit SAT = 1'b1
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] v,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DIG_W-1:0]         thd,
    output logic [DIG_W-1:0]         hud,
    output logic [DIG_W-1:0]         ten,
    output logic [DIG_W-1:0]         one,
    output logic                     neg,
    output logic                     ovf
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);
    localparam logic [1:0] LAST_DIG = 2'(NDIG - 1);

    state_t            state;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] v_abs;
    logic [DIG_W-1:0]  rem;
    logic [DIG_W-1:0]  rem_nxt;
    logic              q_bit;
    logic [3:0]        bit_cnt;
    logic [1:0]        dig_idx;
    logic [DIG_W-1:0]  dig [NDIG];
    logic              neg_r;
    logic              ovf_r;

    // 0x8000 negates to itself, which read unsigned is the required 32768.
    assign v_abs = v[DATA_W-1] ? (~$unsigned(v)) + DATA_W'(1) : $unsigned(v);

    div10_step u_step (
        .rem_in  (rem),
        .bit_in  (mag[DATA_W-1]),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rem       <= '0;
            bit_cnt   <= '0;
            dig_idx   <= '0;
            neg_r     <= 1'b0;
            ovf_r     <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                dig[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag      <= v_abs;
                        neg_r    <= v[DATA_W-1];
                        rem      <= '0;
                        bit_cnt  <= '0;
                        dig_idx  <= '0;
                        in_ready <= 1'b0;
                        state    <= DIV;
                    end
                end
                DIV: begin
                    // The quotient replaces the dividend in place, so the next
                    // digit divides the running quotient again.
                    mag     <= {mag[DATA_W-2:0], q_bit};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        dig[dig_idx] <= rem_nxt;
                        rem          <= '0;
                        dig_idx      <= dig_idx + 2'd1;
                        if (dig_idx == LAST_DIG) begin
                            state <= FIN;
                        end
                    end else begin
                        rem <= rem_nxt;
                    end
                end
                FIN: begin
                    ovf_r <= (mag != '0);
                    if (SAT && (mag != '0)) begin
                        for (int i = 0; i < NDIG; i++) begin
                            dig[i] <= DIG_W'(DEC_BASE - 1);
                        end
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign one = dig[0];
    assign ten = dig[1];
    assign hud = dig[2];
    assign thd = dig[3];
    assign neg = neg_r;
    assign ovf = ovf_r;

endmodule

// File: tb/tb_digit_split_seq.sv
// Bench for digit_split_seq: one saturating and one wrapping instance driven in lockstep.
module tb_digit_split_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] v;

    logic       ir_a, ov_a, neg_a, ovf_a;
    logic [3:0] thd_a, hud_a, ten_a, one_a;
    logic       ir_b, ov_b, neg_b, ovf_b;
    logic [3:0] thd_b, hud_b, ten_b, one_b;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    digit_split_seq #(.SAT(1'b1)) u_sat1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .v(v),
        .out_valid(ov_a), .out_ready(out_ready),
        .thd(thd_a), .hud(hud_a), .ten(ten_a), .one(one_a), .neg(neg_a), .ovf(ovf_a)
    );

    digit_split_seq #(.SAT(1'b0)) u_sat0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .v(v),
        .out_valid(ov_b), .out_ready(out_ready),
        .thd(thd_b), .hud(hud_b), .ten(ten_b), .one(one_b), .neg(neg_b), .ovf(ovf_b)
    );

    // Observed layout: {in_ready, out_valid, neg, ovf, thd, hud, ten, one}
    function automatic logic [19:0] obs_a();
        return {ir_a, ov_a, neg_a, ovf_a, thd_a, hud_a, ten_a, one_a};
    endfunction

    function automatic logic [19:0] obs_b();
        return {ir_b, ov_b, neg_b, ovf_b, thd_b, hud_b, ten_b, one_b};
    endfunction

    // Reference: decimal digits of |val| by plain arithmetic.
    function automatic logic [17:0] model(input logic [15:0] val, input bit sat);
        int         m;
        bit         o;
        logic [3:0] d [4];
        m = val[15] ? 65536 - int'(val) : int'(val);
        o = (m > 9999);
        for (int k = 0; k < 4; k++) begin
            d[k] = 4'(m % 10);
            m    = m / 10;
        end
        if (sat && o) begin
            for (int k = 0; k < 4; k++) d[k] = 4'd9;
        end
        return {val[15], o, d[3], d[2], d[1], d[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept val on the next edge, then wait (bounded) for out_valid.
    task automatic run_conv(input logic [15:0] val, input bit noise, output int lat);
        in_valid = 1'b1;
        v        = val;
        tick();
        in_valid = 1'b0;
        v        = 16'($urandom);
        lat      = 0;
        while (ov_a !== 1'b1 && lat < 200) begin
            if (noise) begin
                in_valid = 1'($urandom);
                v        = 16'($urandom);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; v = '0;
        repeat (2) tick();
        rst = 1'b0;
        nvec++;
        if (obs_a() !== 20'h80000) begin
            nfail++; $display("FAIL reset_sat1: got %h want %h", obs_a(), 20'h80000);
        end
        nvec++;
        if (obs_b() !== 20'h80000) begin
            nfail++; $display("FAIL reset_sat0: got %h want %h", obs_b(), 20'h80000);
        end
    endtask

    task automatic test_directed();
        logic [15:0] vals [10] = '{16'h04D2, 16'hFECF, 16'd12345, 16'h8000, 16'h0000,
                                   16'd9999, 16'hFFFF, 16'd10000, 16'h7FFF, 16'hD8F1};
        logic [19:0] ea, eb;
        int lat;
        out_ready = 1'b1;
        foreach (vals[i]) begin
            run_conv(vals[i], 1'b0, lat);
            ea = {2'b01, model(vals[i], 1'b1)};
            eb = {2'b01, model(vals[i], 1'b0)};
            nvec++;
            if (lat != 65) begin
                nfail++; $display("FAIL dir_latency v=%h: got %0d want 65", vals[i], lat);
            end
            nvec++;
            if (obs_a() !== ea) begin
                nfail++; $display("FAIL dir_sat1 v=%h: got %h want %h", vals[i], obs_a(), ea);
            end
            nvec++;
            if (obs_b() !== eb) begin
                nfail++; $display("FAIL dir_sat0 v=%h: got %h want %h", vals[i], obs_b(), eb);
            end
            tick();
            nvec++;
            if ({ir_a, ov_a, ir_b, ov_b} !== 4'b1010) begin
                nfail++; $display("FAIL dir_pop v=%h: got %b want 1010", vals[i], {ir_a, ov_a, ir_b, ov_b});
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] val;
        logic [19:0] ea, eb;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            val = 16'($urandom);
            run_conv(val, i[0], lat);
            ea = {2'b01, model(val, 1'b1)};
            eb = {2'b01, model(val, 1'b0)};
            nvec++;
            if (lat != 65) begin
                nfail++; $display("FAIL rnd_latency v=%h: got %0d want 65", val, lat);
            end
            nvec++;
            if (obs_a() !== ea) begin
                nfail++; $display("FAIL rnd_sat1 v=%h: got %h want %h", val, obs_a(), ea);
            end
            nvec++;
            if (obs_b() !== eb) begin
                nfail++; $display("FAIL rnd_sat0 v=%h: got %h want %h", val, obs_b(), eb);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] val;
        logic [19:0] ea, eb;
        int lat;
        out_ready = 1'b0;
        val = 16'hFECF;
        run_conv(val, 1'b1, lat);
        ea = {2'b01, model(val, 1'b1)};
        eb = {2'b01, model(val, 1'b0)};
        nvec++;
        if (lat != 65) begin
            nfail++; $display("FAIL bp_latency: got %0d want 65", lat);
        end
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'($urandom);
            v        = 16'($urandom);
            tick();
            nvec++;
            if (obs_a() !== ea || obs_b() !== eb) begin
                nfail++; $display("FAIL bp_hold cycle %0d: got %h/%h want %h/%h", k, obs_a(), obs_b(), ea, eb);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        nvec++;
        if ({ir_a, ov_a, ir_b, ov_b} !== 4'b1010) begin
            nfail++; $display("FAIL bp_release: got %b want 1010", {ir_a, ov_a, ir_b, ov_b});
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] ea;
        int lat;
        out_ready = 1'b0;
        run_conv(16'd777, 1'b0, lat);
        // Offer the next value on the handshake edge itself; it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        v         = 16'd42;
        tick();
        nvec++;
        if ({ir_a, ov_a, ir_b, ov_b} !== 4'b1010) begin
            nfail++; $display("FAIL b2b_no_bypass: got %b want 1010", {ir_a, ov_a, ir_b, ov_b});
        end
        run_conv(16'd42, 1'b0, lat);
        ea = {2'b01, model(16'd42, 1'b1)};
        nvec++;
        if (lat != 65 || obs_a() !== ea) begin
            nfail++; $display("FAIL b2b_second: got lat %0d val %h want lat 65 val %h", lat, obs_a(), ea);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        logic [19:0] ea, eb;
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        v         = 16'hEF1F;
        tick();
        in_valid = 1'b0;
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++;
        if (obs_a() !== 20'h80000 || obs_b() !== 20'h80000) begin
            nfail++; $display("FAIL midreset: got %h/%h want 80000", obs_a(), obs_b());
        end
        run_conv(16'd9999, 1'b0, lat);
        ea = {2'b01, model(16'd9999, 1'b1)};
        eb = {2'b01, model(16'd9999, 1'b0)};
        nvec++;
        if (lat != 65 || obs_a() !== ea || obs_b() !== eb) begin
            nfail++; $display("FAIL midreset_after: got lat %0d %h/%h want lat 65 %h/%h", lat, obs_a(), obs_b(), ea, eb);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d of %0d compares bad", nfail, nvec);
        $fatal(1, "time limit");
    end

endmodule
